// File: rtl/bit_deser_pkg.sv
// Shared types and default constants for the bit deserializer.
package bit_deser_pkg;

    // Word-alignment FSM: hunting for the sync word, or aligned to it.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } deser_state_t;

    localparam int         DESER_WIDTH   = 8;
    localparam logic [7:0] DESER_SYNC    = 8'hA5;
    localparam int         DESER_MAX_GAP = 4;
    localparam int         ERR_CNT_W     = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bit_deser_shifter.sv
// Serial shift register plus fill counter. Exposes the word as it will be
// after the current bit is shifted in, and whether that word is complete.
module bit_deser_shifter
    import bit_deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] word,       // {shreg[WIDTH-2:0], din}
    output logic             full        // WIDTH bits received, counting din
);

    localparam int FILL_W = $clog2(WIDTH + 1);

    // Only the youngest WIDTH-1 bits are stored: the oldest bit of a WIDTH-bit
    // register would be shifted out before it is ever part of a post-shift word.
    logic [WIDTH-2:0]  shreg_q, shreg_d;
    logic [FILL_W-1:0] fill_q,  fill_d;

    // Next-state: shift and count on qualified bits only, fill saturates at WIDTH.
    always_comb begin
        shreg_d = shreg_q;
        fill_d  = fill_q;
        if (din_valid) begin
            shreg_d = word[WIDTH-2:0];
            if (fill_q != FILL_W'(WIDTH)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Shift register and fill counter flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
        end
    end

    assign word = {shreg_q, din};
    assign full = (fill_q >= FILL_W'(WIDTH - 1));

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receive stage: hunts for a sync word, locks alignment,
// emits aligned data words with a one-cycle strobe, and drops lock when too
// many data words pass without a fresh sync word.
module bit_deserializer
    import bit_deser_pkg::*;
#(
    parameter int               WIDTH     = DESER_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DESER_SYNC),
    parameter int               MAX_GAP   = DESER_MAX_GAP
) (
    input  logic                 clk,
    input  logic                 rst,         // asynchronous, active-low
    input  logic                 din,
    input  logic                 din_valid,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 dbg_state    // 0 = HUNT, 1 = LOCKED
);

    localparam int BC_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = $clog2(MAX_GAP + 1);

    logic [WIDTH-1:0] word;
    logic             full;

    bit_deser_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .word      (word),
        .full      (full)
    );

    deser_state_t         state_q,      state_d;
    logic [BC_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q,    gap_cnt_d;
    logic [WIDTH-1:0]     dout_q,       dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 sync_err_q,   sync_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

    // FSM and word classification; everything holds when din_valid is low,
    // and the two pulse outputs default to zero every cycle.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        err_cnt_d    = err_cnt_q;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Bit-by-bit search; the matched sync word itself is not output.
                    if (full && (word == SYNC_WORD)) begin
                        state_d   = LOCKED;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (word == SYNC_WORD) begin
                            gap_cnt_d = '0;
                        end else if (gap_cnt_q < GAP_W'(MAX_GAP)) begin
                            dout_d       = word;
                            dout_valid_d = 1'b1;
                            gap_cnt_d    = gap_cnt_q + 1'b1;
                        end else begin
                            // Too long without sync: drop the word and the lock.
                            // Shift register is kept so hunting resumes at once.
                            sync_err_d = 1'b1;
                            err_cnt_d  = sat_inc(err_cnt_q);
                            state_d    = HUNT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = sync_err_q;
    assign err_cnt    = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer: a table of whole-word vectors walked in
// order, plus hand sequences for reset, misalignment, valid gaps and saturation.
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_cnt;
    logic       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int serr_cnt   = 0;

    bit_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (dout_valid) strobe_cnt++;
        if (sync_err)   serr_cnt++;
    end

    typedef struct {
        logic [7:0] word;
        logic       exp_v;
        logic [7:0] exp_dout;
        logic       exp_locked;
        logic       exp_serr;
        logic [7:0] exp_errc;
        logic       lk_all;   // locked expected high through the word's first bits
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one bit, then land on the following negedge
    task automatic send_bit(input logic b, input logic v);
        din = b;
        din_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    // MSB first; no pulse may appear before the last bit
    task automatic send_word(input logic [7:0] w, input logic lk_all, input string tag);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], 1'b1);
            if (i != 0) begin
                check({tag, " mid dout_valid"}, 32'(dout_valid), 32'd0);
                check({tag, " mid sync_err"}, 32'(sync_err), 32'd0);
                if (lk_all) check({tag, " mid locked"}, 32'(locked), 32'd1);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic check_word_end(input string tag, input logic v, input logic [7:0] d,
                                  input logic l, input logic s, input logic [7:0] e);
        check({tag, " dout_valid"}, 32'(dout_valid), 32'(v));
        check({tag, " dout"}, 32'(dout), 32'(d));
        check({tag, " locked"}, 32'(locked), 32'(l));
        check({tag, " dbg_state"}, 32'(dbg_state), 32'(l));
        check({tag, " sync_err"}, 32'(sync_err), 32'(s));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(e));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dout"}, 32'(dout), 32'd0);
        check({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, " locked"}, 32'(locked), 32'd0);
        check({tag, " sync_err"}, 32'(sync_err), 32'd0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int s0, v0, e_exp;

        vecs[0]  = '{8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[2]  = '{8'h02, 1'b1, 8'h02, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[3]  = '{8'h03, 1'b1, 8'h03, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[4]  = '{8'h04, 1'b1, 8'h04, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[5]  = '{8'h05, 1'b0, 8'h04, 1'b0, 1'b1, 8'd1, 1'b1};
        vecs[6]  = '{8'hA5, 1'b0, 8'h04, 1'b1, 1'b0, 8'd1, 1'b0};
        vecs[7]  = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[8]  = '{8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[9]  = '{8'h33, 1'b1, 8'h33, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[10] = '{8'h44, 1'b1, 8'h44, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[11] = '{8'hA5, 1'b0, 8'h44, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[12] = '{8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[13] = '{8'h66, 1'b1, 8'h66, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[14] = '{8'h77, 1'b1, 8'h77, 1'b1, 1'b0, 8'd1, 1'b1};
        vecs[15] = '{8'h88, 1'b1, 8'h88, 1'b1, 1'b0, 8'd1, 1'b1};

        // reset state
        @(negedge clk);
        check_all_zero("reset");
        check("reset dbg_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // table: lock, loss of lock, relock, sync refresh
        s0 = strobe_cnt;
        v0 = serr_cnt;
        for (int k = 0; k < 16; k++) begin
            if (k == 6) begin
                #1;
                check("loss strobes", 32'(strobe_cnt - s0), 32'd4);
                check("loss sync_err pulses", 32'(serr_cnt - v0), 32'd1);
                s0 = strobe_cnt;
                v0 = serr_cnt;
            end
            send_word(vecs[k].word, vecs[k].lk_all, $sformatf("vec%0d", k));
            check_word_end($sformatf("vec%0d", k), vecs[k].exp_v, vecs[k].exp_dout,
                           vecs[k].exp_locked, vecs[k].exp_serr, vecs[k].exp_errc);
        end
        #1;
        check("refresh strobes", 32'(strobe_cnt - s0), 32'd8);
        check("refresh sync_err pulses", 32'(serr_cnt - v0), 32'd0);

        // reset mid-stream: async assertion, outputs zero throughout
        send_word(8'hA5, 1'b0, "pre_rst sync");
        for (int i = 7; i >= 4; i--) send_bit(logic'(i[0]), 1'b1);
        check("pre_rst locked", 32'(locked), 32'd1);
        #2 rst = 1'b0;
        #1 check_all_zero("rst async");
        for (int c = 0; c < 3; c++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b1);
            check_all_zero($sformatf("rst cyc%0d", c));
        end
        rst = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        send_word(8'hA5, 1'b0, "post_rst sync");
        check_word_end("post_rst sync", 1'b0, 8'h00, 1'b1, 1'b0, 8'd0);
        send_word(8'h3C, 1'b1, "post_rst data");
        check_word_end("post_rst data", 1'b1, 8'h3C, 1'b1, 1'b0, 8'd0);

        // misalignment: junk 101 then sync, then data
        do_reset();
        s0 = strobe_cnt;
        v0 = serr_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check("mis junk locked", 32'(locked), 32'd0);
        for (int i = 7; i >= 1; i--) send_bit(logic'((8'hA5 >> i) & 8'h01), 1'b1);
        check("mis before last locked", 32'(locked), 32'd0);
        send_bit(1'b1, 1'b1);
        check("mis lock on last bit", 32'(locked), 32'd1);
        send_word(8'hF0, 1'b1, "mis data");
        check_word_end("mis data", 1'b1, 8'hF0, 1'b1, 1'b0, 8'd0);
        #1;
        check("mis strobes", 32'(strobe_cnt - s0), 32'd1);
        check("mis sync_err pulses", 32'(serr_cnt - v0), 32'd0);

        // valid gaps: every other cycle unqualified, garbage on din
        s0 = strobe_cnt;
        for (int i = 7; i >= 0; i--) begin
            send_bit(logic'((8'h81 >> i) & 8'h01), 1'b1);
            if (i != 0) begin
                send_bit(1'($urandom_range(0, 1)), 1'b0);
                check("gap dout_valid", 32'(dout_valid), 32'd0);
                check("gap dout hold", 32'(dout), 32'hF0);
                check("gap locked", 32'(locked), 32'd1);
            end
        end
        check_word_end("gap data", 1'b1, 8'h81, 1'b1, 1'b0, 8'd0);
        send_bit(1'b0, 1'b0);
        check("gap idle dout_valid", 32'(dout_valid), 32'd0);
        check("gap idle dout hold", 32'(dout), 32'h81);
        #1;
        check("gap strobes", 32'(strobe_cnt - s0), 32'd1);

        // saturation: 256 lock losses
        do_reset();
        for (int ev = 0; ev < 256; ev++) begin
            v0 = serr_cnt;
            send_word(8'hA5, 1'b0, "sat sync");
            check("sat locked", 32'(locked), 32'd1);
            for (int d = 0; d < 4; d++) send_word(8'h00, 1'b1, "sat data");
            send_word(8'h00, 1'b1, "sat drop");
            e_exp = (ev + 1 > 255) ? 255 : ev + 1;
            check("sat sync_err", 32'(sync_err), 32'd1);
            check("sat err_cnt", 32'(err_cnt), 32'(e_exp));
            check("sat unlocked", 32'(locked), 32'd0);
            #1;
            check("sat pulse count", 32'(serr_cnt - v0), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
